// File: rtl/efuse_pkg.sv
// Shared eFuse definitions for the program and read controllers: FSM states,
// macro size, inter-pulse gap and the offset-to-data-bit mapping.
package efuse_pkg;

    localparam int EFUSE_BITS  = 256;
    localparam int PGM_GAP_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ADDR,
        ST_PULSE,
        ST_GAP,
        ST_HOLD
    } efuse_state_e;

    // Offset 8k+j maps to data bit np-8-8k+j so the first byte read lands in the MSBs.
    function automatic logic [7:0] efuseBitIdx(input logic [8:0] np, input logic [7:0] offset);
        logic [8:0] w_idx;
        w_idx = np - 9'd8 - {1'b0, offset[7:3], 3'b000} + {6'b0, offset[2:0]};
        return w_idx[7:0];
    endfunction

endpackage

// File: rtl/efuse_tick_cnt.sv
// Clearable 9-bit tick counter with terminal-count compare, shared by the
// eFuse program and read timing paths.
module efuse_tick_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic [8:0] i_limit,
    output logic       o_done
);

    logic [8:0] r_count;

    assign o_done = (r_count == i_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 9'd1;
        end
    end

endmodule

// File: rtl/efuse_pgm.sv
// eFuse program controller: burns every '1' bit of a latched segment word with a
// timed AEN pulse under PGMEN. Define EFUSE_PGM_SKIP_ZERO_EN to skip '0' bit slots.
module efuse_pgm
    import efuse_pkg::*;
#(
    parameter int NP   = 64,
    parameter int PSEL = EFUSE_BITS / NP,
    parameter int SW   = (PSEL > 1) ? $clog2(PSEL) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rg_efuse_tpgm,
    input  logic [3:0]    rg_efuse_tsu,
    input  logic [SW-1:0] pgm_sel,
    input  logic [NP-1:0] pgm_data,
    input  logic          pgm_start,
    output logic          pgm_done,
    output logic          busy_pgm,
    output logic          efuse_pgmen_o,
    output logic          efuse_rden_o,
    output logic          efuse_aen_o,
    output logic [7:0]    efuse_addr_o
);

    localparam int OW = $clog2(NP);

    efuse_state_e  r_state;
    logic [NP-1:0] r_data;
    logic [SW-1:0] r_sel;
    logic [7:0]    r_tpgm;
    logic [3:0]    r_tsu;
    logic [OW-1:0] r_offset;
    logic [7:0]    r_addr;
    logic          r_aen;
    logic          r_pgmen;
    logic          r_busy;
    logic          r_done;

    logic [8:0]    w_tickLimit;
    logic          w_tickDone;
    logic [OW-1:0] w_bitIdx;
    logic          w_bit;
    logic          w_lastBit;
    logic [OW-1:0] w_nextOffset;
    logic [7:0]    w_base;
    logic [7:0]    w_nextAddr;

    assign w_bitIdx     = OW'(efuseBitIdx(9'(NP), 8'(r_offset)));
    assign w_bit        = r_data[w_bitIdx];
    assign w_lastBit    = (r_offset == OW'(NP - 1));
    assign w_nextOffset = r_offset + OW'(1);
    assign w_base       = 8'(32'(r_sel) * 32'(NP));
    assign w_nextAddr   = w_base + 8'(w_nextOffset);

    // Every state leaves exactly when its tick count is reached, so the terminal
    // count doubles as the clear that restarts the counter on each state entry.
    always_comb begin
        w_tickLimit = '0;
        case (r_state)
            ST_SETUP, ST_HOLD: w_tickLimit = {5'd0, r_tsu};
            ST_PULSE:          w_tickLimit = {1'b0, r_tpgm};
            ST_GAP:            w_tickLimit = 9'(PGM_GAP_CYC - 1);
            default:           w_tickLimit = '0;
        endcase
    end

    efuse_tick_cnt u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_tickDone),
        .i_limit (w_tickLimit),
        .o_done  (w_tickDone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_data   <= '0;
            r_sel    <= '0;
            r_tpgm   <= '0;
            r_tsu    <= '0;
            r_offset <= '0;
            r_addr   <= '0;
            r_aen    <= 1'b0;
            r_pgmen  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pgm_start) begin
                        r_data  <= pgm_data;
                        r_sel   <= pgm_sel;
                        r_tpgm  <= rg_efuse_tpgm;
                        r_tsu   <= rg_efuse_tsu;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_pgmen <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tickDone) begin
                        r_offset <= '0;
                        r_addr   <= w_base;
                        r_state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
`ifdef EFUSE_PGM_SKIP_ZERO_EN
                    if (w_bit) begin
                        r_aen   <= 1'b1;
                        r_state <= ST_PULSE;
                    end else if (w_lastBit) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_offset <= w_nextOffset;
                        r_addr   <= w_nextAddr;
                    end
`else
                    r_aen   <= w_bit;
                    r_state <= ST_PULSE;
`endif
                end
                ST_PULSE: begin
                    if (w_tickDone) begin
                        r_aen   <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tickDone) begin
                        if (w_lastBit) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_offset <= w_nextOffset;
                            r_addr   <= w_nextAddr;
                            r_state  <= ST_ADDR;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tickDone) begin
                        r_pgmen <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pgm_done      = r_done;
    assign busy_pgm      = r_busy;
    assign efuse_pgmen_o = r_pgmen;
    assign efuse_rden_o  = 1'b0;
    assign efuse_aen_o   = r_aen;
    assign efuse_addr_o  = r_addr;

endmodule

// File: tb/tb_efuse_pgm.sv
// Scoreboard bench for efuse_pgm: expected pulses and completion latency are
// queued at start; a negedge monitor pops them and models the fuse array.
module tb_efuse_pgm;

    localparam int NP       = 64;
    localparam int PSEL     = 256 / NP;
    localparam int MAX_WAIT = 20000;

    typedef struct {
        logic [7:0] addr;
        int         width;
    } pulse_t;

    typedef struct {
        int            latency;
        int            sel;
        logic [NP-1:0] data;
    } done_t;

    logic          clk;
    logic          rst_n;
    logic [7:0]    rg_efuse_tpgm;
    logic [3:0]    rg_efuse_tsu;
    logic [1:0]    pgm_sel;
    logic [NP-1:0] pgm_data;
    logic          pgm_start;
    logic          pgm_done;
    logic          busy_pgm;
    logic          efuse_pgmen_o;
    logic          efuse_rden_o;
    logic          efuse_aen_o;
    logic [7:0]    efuse_addr_o;

    pulse_t        pulseQ[$];
    done_t         doneQ[$];
    logic [255:0]  fuse;
    logic [NP-1:0] segExp [PSEL];
    int            checks = 0;
    int            fails = 0;
    int            cycle = 0;
    int            startCycle = 0;
    logic          prevAen = 1'b0;
    logic          prevDone = 1'b0;
    int            pulseWidth = 0;
    logic [7:0]    pulseAddr = '0;

    efuse_pgm #(.NP(NP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rg_efuse_tpgm (rg_efuse_tpgm),
        .rg_efuse_tsu  (rg_efuse_tsu),
        .pgm_sel       (pgm_sel),
        .pgm_data      (pgm_data),
        .pgm_start     (pgm_start),
        .pgm_done      (pgm_done),
        .busy_pgm      (busy_pgm),
        .efuse_pgmen_o (efuse_pgmen_o),
        .efuse_rden_o  (efuse_rden_o),
        .efuse_aen_o   (efuse_aen_o),
        .efuse_addr_o  (efuse_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic finishTest();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    endtask

    // Reference model: one pulse per '1' bit in burn order, latency from slot costs.
    task automatic applyStimulus(input int sel, input logic [NP-1:0] data, input int tpgm, input int tsu);
        done_t  d;
        pulse_t p;
        int     lat;
        logic   b;
        lat = 2 * (tsu + 1);
        for (int o = 0; o < NP; o++) begin
            b = data[NP - 8 - 8 * (o / 8) + (o % 8)];
            if (b) begin
                p.addr  = 8'(NP * sel + o);
                p.width = tpgm + 1;
                pulseQ.push_back(p);
                lat += tpgm + 4;
            end else begin
`ifdef EFUSE_PGM_SKIP_ZERO_EN
                lat += 1;
`else
                lat += tpgm + 4;
`endif
            end
        end
        d.latency = lat;
        d.sel     = sel;
        d.data    = data;
        doneQ.push_back(d);

        @(negedge clk);
        pgm_sel       = 2'(sel);
        pgm_data      = data;
        rg_efuse_tpgm = 8'(tpgm);
        rg_efuse_tsu  = 4'(tsu);
        pgm_start     = 1'b1;
        @(negedge clk);
        pgm_start  = 1'b0;
        startCycle = cycle;
        checkOutput("startBusy", 64'(busy_pgm), 64'd1);
        checkOutput("startPgmen", 64'(efuse_pgmen_o), 64'd1);
        checkOutput("startDone", 64'(pgm_done), 64'd0);
        pgm_data      = {$urandom, $urandom};
        pgm_sel       = 2'($urandom_range(0, 3));
        rg_efuse_tpgm = 8'($urandom);
        rg_efuse_tsu  = 4'($urandom);
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (busy_pgm && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_finish"}, 64'(busy_pgm), 64'd0);
        if (busy_pgm) finishTest();
        @(negedge clk);
        checkOutput({name, "_pulsesLeft"}, 64'(pulseQ.size()), 64'd0);
        checkOutput({name, "_doneLeft"}, 64'(doneQ.size()), 64'd0);
    endtask

    task automatic checkReadback(input int sel);
        logic [NP-1:0] rd;
        rd = '0;
        for (int o = 0; o < NP; o++) rd[NP - 8 - 8 * (o / 8) + (o % 8)] = fuse[NP * sel + o];
        checkOutput($sformatf("readback%0d", sel), 64'(rd), 64'(segExp[sel]));
    endtask

    // Monitor: matches AEN pulses and pgm_done rises against the queued expectations.
    always @(negedge clk) begin
        pulse_t p;
        done_t  d;
        if (!rst_n) begin
            prevAen  = 1'b0;
            prevDone = 1'b0;
        end else begin
            if (efuse_aen_o) checkOutput("aenNeedsPgmen", 64'(efuse_pgmen_o), 64'd1);
            if (efuse_aen_o && !prevAen) begin
                pulseWidth = 1;
                pulseAddr  = efuse_addr_o;
            end else if (efuse_aen_o) begin
                pulseWidth++;
                checkOutput("addrStable", 64'(efuse_addr_o), 64'(pulseAddr));
            end else if (prevAen) begin
                if (pulseQ.size() == 0) begin
                    checkOutput("unexpectedPulse", 64'(pulseAddr), 64'hFFFF);
                end else begin
                    p = pulseQ.pop_front();
                    checkOutput("pulseAddr", 64'(pulseAddr), 64'(p.addr));
                    checkOutput("pulseWidth", 64'(pulseWidth), 64'(p.width));
                end
                fuse[pulseAddr] = 1'b1;
            end
            if (pgm_done && !prevDone) begin
                if (doneQ.size() == 0) begin
                    checkOutput("unexpectedDone", 64'(pgm_done), 64'd0);
                end else begin
                    d = doneQ.pop_front();
                    checkOutput("doneLatency", 64'(cycle - startCycle), 64'(d.latency));
                    checkOutput("doneBusy", 64'(busy_pgm), 64'd0);
                    checkOutput("donePgmen", 64'(efuse_pgmen_o), 64'd0);
                    checkOutput("doneRden", 64'(efuse_rden_o), 64'd0);
                    segExp[d.sel] = segExp[d.sel] | d.data;
                end
            end
            prevAen  = efuse_aen_o;
            prevDone = pgm_done;
        end
    end

    initial begin
        logic [NP-1:0] dReset;
        int n;
        fuse = '0;
        for (int s = 0; s < PSEL; s++) segExp[s] = '0;
        rst_n = 1'b0;
        pgm_start = 1'b0;
        pgm_sel = '0;
        pgm_data = '0;
        rg_efuse_tpgm = '0;
        rg_efuse_tsu = '0;
        #12;
        checkOutput("rstDone", 64'(pgm_done), 64'd0);
        checkOutput("rstBusy", 64'(busy_pgm), 64'd0);
        checkOutput("rstPgmen", 64'(efuse_pgmen_o), 64'd0);
        checkOutput("rstRden", 64'(efuse_rden_o), 64'd0);
        checkOutput("rstAen", 64'(efuse_aen_o), 64'd0);
        checkOutput("rstAddr", 64'(efuse_addr_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed: MSB and LSB only");
        applyStimulus(0, 64'h8000_0000_0000_0001, 3, 0);
        waitDone("edgeBits");
        checkOutput("fuse7", 64'(fuse[7]), 64'd1);
        checkOutput("fuse56", 64'(fuse[56]), 64'd1);
        checkOutput("fuseCount", 64'($countones(fuse)), 64'd2);

        $display("[TB] directed: all ones, widest pulse");
        applyStimulus(3, '1, 255, $urandom_range(0, 15));
        waitDone("allOnes");

        $display("[TB] mid-sequence restart ignored");
        applyStimulus(1, {$urandom, $urandom}, 2, 1);
        repeat (30) @(negedge clk);
        pgm_data  = {$urandom, $urandom};
        pgm_start = 1'b1;
        @(negedge clk);
        pgm_start = 1'b0;
        waitDone("restart");

        $display("[TB] reset during pulse");
        dReset = {$urandom, $urandom} | 64'h0100_0000_0000_0000;
        applyStimulus(2, dReset, 5, 1);
        n = 0;
        while (!efuse_aen_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachedPulse", 64'(efuse_aen_o), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("asyncAen", 64'(efuse_aen_o), 64'd0);
        checkOutput("asyncPgmen", 64'(efuse_pgmen_o), 64'd0);
        checkOutput("asyncBusy", 64'(busy_pgm), 64'd0);
        checkOutput("asyncAddr", 64'(efuse_addr_o), 64'd0);
        pulseQ.delete();
        doneQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2, dReset, 4, 2);
        waitDone("afterReset");

        $display("[TB] randomized programs");
        for (int i = 0; i < 6; i++) begin
            applyStimulus($urandom_range(0, 3), {$urandom, $urandom},
                          $urandom_range(0, 6), $urandom_range(0, 3));
            waitDone($sformatf("rand%0d", i));
        end

        for (int s = 0; s < PSEL; s++) checkReadback(s);
        finishTest();
    end

endmodule
